mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter with a lock/ownership FSM and 1-cycle read return.
// Define MEM_ARB_RR_EN for round-robin ties in ARB; the default build uses fixed priority (r0 wins).
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a transaction is accepted at the rising edge where rN_req && rN_gnt;
  // gnt is combinational, and the requester holds its fields stable until accepted.
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {ARB = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t state;
  logic   last_gnt;
  logic   tie_to1;
  logic   gnt0, gnt1;

`ifdef MEM_ARB_RR_EN
  assign tie_to1 = ~last_gnt;
`else
  // Pointer still tracks the last winner but is masked out of the tie decision.
  assign tie_to1 = 1'b0 & ~last_gnt;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      case (state)
        ARB: begin
          if (r0_req && r1_req) begin
            gnt0 = ~tie_to1;
            gnt1 = tie_to1;
          end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
          end
        end
        OWN0:    gnt0 = r0_req;
        OWN1:    gnt1 = r1_req;
        default: ;
      endcase
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  always_comb begin
    mem_cmd   = MNONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_cmd   = r0_write ? MWRITE : MREAD;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_cmd   = r1_write ? MWRITE : MREAD;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      last_gnt  <= 1'b1;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= gnt0 & ~r0_write;
      r1_rvalid <= gnt1 & ~r1_write;
      if (gnt0) begin
        last_gnt <= 1'b0;
        state    <= r0_lock ? OWN0 : ARB;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
        state    <= r1_lock ? OWN1 : ARB;
      end else if (state != ARB) begin
        // An owner without a grant has dropped its request: release ownership.
        state <= ARB;
      end
    end
  end

  assign r0_rdata = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: grant/command vectors plus a read-return scoreboard.
module tb_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          r0_req, r0_write, r0_lock, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_write, r1_lock, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req(r0_req), .r0_write(r0_write), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM environment: read data appears the cycle after the MREAD cycle.
  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] ref_mem [0:511];
  always @(posedge clk) begin
    if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic          q0, w0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          q1, w1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q[$];   // {requester id, expected rdata}
  logic mon_en = 1'b0;
  vec_t vecs[26];

  function automatic vec_t mk(input logic q0, w0, l0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic q1, w1, l1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, g1);
    vec_t v;
    v.q0 = q0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    v.cmd = 2'b00; v.addr = '0; v.wdata = '0;
    if (g0) begin
      v.cmd = w0 ? 2'b10 : 2'b01; v.addr = a0; v.wdata = d0;
    end else if (g1) begin
      v.cmd = w1 ? 2'b10 : 2'b01; v.addr = a1; v.wdata = d1;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    r0_req = v.q0; r0_write = v.w0; r0_lock = v.l0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_req = v.q1; r1_write = v.w1; r1_lock = v.l1; r1_addr = v.a1; r1_wdata = v.d1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    check($sformatf("v%0d_gnt", idx), {62'd0, r0_gnt, r1_gnt}, {62'd0, v.g0, v.g1});
    check($sformatf("v%0d_mem", idx), {mem_cmd, mem_addr, mem_wdata}, {v.cmd, v.addr, v.wdata});
    if (v.g0) begin
      if (v.w0) ref_mem[v.a0] = v.d0;
      else exp_q.push_back({1'b0, ref_mem[v.a0]});
    end
    if (v.g1) begin
      if (v.w1) ref_mem[v.a1] = v.d1;
      else exp_q.push_back({1'b1, ref_mem[v.a1]});
    end
  endtask

  // Each negedge: exactly the read accepted in the previous cycle (if any) must be returning.
  always @(negedge clk) begin
    logic [2*DW+1:0] exp_v;
    logic [DW:0]     e;
    if (mon_en) begin
      exp_v = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[DW]) exp_v = {1'b0, 1'b1, {DW{1'b0}}, e[DW-1:0]};
        else       exp_v = {1'b1, 1'b0, e[DW-1:0], {DW{1'b0}}};
      end
      check("rvalid_rdata", {30'd0, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata}, {30'd0, exp_v});
    end
  end

  vec_t idle;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]     = 16'(i * 7 + 16'h0100);
      ref_mem[i] = 16'(i * 7 + 16'h0100);
    end
    ram[5] = 16'h4321; ref_mem[5] = 16'h4321;
    ram[1] = 16'hA001; ref_mem[1] = 16'hA001;
    ram[2] = 16'hB002; ref_mem[2] = 16'hB002;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = idle;
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 7, 16'hFAFA, 0, 1);
    vecs[3]  = idle;
    vecs[4]  = mk(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[5]  = idle;
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1);
`ifdef MEM_ARB_RR_EN
    vecs[7]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 1, 0);
    vecs[8]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 1, 0);
    vecs[10] = mk(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0, 1);
`else
    for (int i = 7; i <= 10; i++) vecs[i] = mk(1, 0, 0, 1, 0, 1, 0, 0, 2, 0, 1, 0);
`endif
    vecs[11] = idle;
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 1, 4, 0, 0, 1);
    for (int i = 13; i <= 15; i++) vecs[i] = mk(1, 0, 0, 1, 0, 1, 0, 1, 4, 0, 0, 1);
    vecs[16] = mk(1, 0, 0, 1, 0, 1, 0, 0, 4, 0, 0, 1);
    vecs[17] = mk(1, 0, 0, 1, 0, 1, 0, 0, 4, 0, 1, 0);
    vecs[18] = idle;
    vecs[19] = mk(1, 1, 1, 9, 16'h1234, 0, 0, 0, 0, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 0, 1);
    vecs[22] = idle;
    vecs[23] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[24] = mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[25] = idle;

    // Clock/reset: requests during reset must not be granted.
    drive(idle);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    r0_req = 1'b1; r0_addr = 5;
    #1;
    check("rst_gnt", {62'd0, r0_gnt, r1_gnt}, 64'd0);
    check("rst_mem", {mem_cmd, mem_addr, mem_wdata}, 64'd0);
    repeat (2) @(negedge clk);
    drive(idle);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++) apply(vecs[i], i);

    // Reset asserted just after a read accept: the pending read must vanish.
    apply(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0), 100);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    drive(idle);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) apply(idle, 101 + i);
    apply(mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0), 104);
    apply(idle, 105);
    @(negedge clk);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
